// File: rtl/commit_stage_multi.sv
// commit_stage_multi: N-port in-order retirement stage.
// Retires a prefix of the head window each cycle, allows one store per cycle,
// and sends serialising ops (fences, AMOs) through a small drain/wait FSM.
module commit_stage_multi #(
  parameter int NR_PORTS    = 4,
  parameter int XLEN        = 64,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     halt_i,
  input  logic                     single_step_i,
  input  logic [NR_PORTS-1:0]      valid_i,
  input  logic [NR_PORTS-1:0]      ex_valid_i,
  input  logic [NR_PORTS*3-1:0]    fu_i,
  input  logic [NR_PORTS*2-1:0]    serial_i,
  input  logic [NR_PORTS-1:0]      amo_i,
  input  logic [NR_PORTS*5-1:0]    rd_i,
  input  logic [NR_PORTS*XLEN-1:0] result_i,
  input  logic [NR_PORTS*5-1:0]    fflags_i,
  input  logic                     lsu_ready_i,
  input  logic                     no_st_pending_i,
  input  logic                     amo_ack_i,
  input  logic [XLEN-1:0]          amo_result_i,
  input  logic [XLEN-1:0]          csr_rdata_i,
  input  logic                     csr_ex_i,
  output logic [NR_PORTS-1:0]      commit_ack_o,
  output logic [NR_PORTS-1:0]      we_gpr_o,
  output logic [NR_PORTS*5-1:0]    waddr_o,
  output logic [NR_PORTS*XLEN-1:0] wdata_o,
  output logic                     commit_lsu_o,
  output logic [2:0]               commit_lsu_port_o,
  output logic                     csr_commit_o,
  output logic                     fflags_we_o,
  output logic [4:0]               fflags_o,
  output logic                     fence_o,
  output logic                     fence_i_o,
  output logic                     sfence_vma_o,
  output logic                     flush_commit_o,
  output logic                     amo_valid_commit_o,
  output logic                     exception_valid_o,
  output logic [63:0]              instret_o,
  output logic                     drain_timeout_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_AMO   = 2'd2;

  localparam logic [2:0] FU_NONE  = 3'd0;
  localparam logic [2:0] FU_STORE = 3'd3;
  localparam logic [2:0] FU_CSR   = 3'd6;
  localparam logic [2:0] FU_FPU   = 3'd7;

  localparam logic [1:0] SER_FENCE   = 2'd1;
  localparam logic [1:0] SER_FENCE_I = 2'd2;
  localparam logic [1:0] SER_SFENCE  = 2'd3;

  localparam int            CW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic                fence_q, fence_d;
  logic                fence_i_q, fence_i_d;
  logic                sfence_q, sfence_d;
  logic [63:0]         instret_q, instret_d;

  logic [NR_PORTS-1:0] ack;
  logic [NR_PORTS-1:0] we;
  logic                sel_csr;
  logic                sel_amo;
  logic                store_taken;
  logic                port_ok;
  logic [3:0]          n_ret;

  // Only plain single-cycle units may retire behind the head entry.
  function automatic logic tail_fu_ok(input logic [2:0] f);
    return (f != FU_NONE) && (f != FU_CSR);
  endfunction

  // Retirement decision, FSM next state and drain bookkeeping.
  always_comb begin
    ack                = '0;
    we                 = '0;
    sel_csr            = 1'b0;
    sel_amo            = 1'b0;
    store_taken        = 1'b0;
    port_ok            = 1'b0;
    commit_lsu_o       = 1'b0;
    commit_lsu_port_o  = 3'd0;
    csr_commit_o       = 1'b0;
    exception_valid_o  = 1'b0;
    flush_commit_o     = 1'b0;
    amo_valid_commit_o = 1'b0;
    fence_d            = 1'b0;
    fence_i_d          = 1'b0;
    sfence_d           = 1'b0;
    state_d            = state_q;
    cnt_d              = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (valid_i[0] && !halt_i &&
            (ex_valid_i[0] || ((fu_i[2:0] == FU_CSR) && csr_ex_i))) begin
          exception_valid_o = 1'b1;
        end else if (valid_i[0] && !halt_i) begin
          if (serial_i[1:0] != 2'd0) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
          end else if (amo_i[0]) begin
            state_d = ST_AMO;
          end else if (fu_i[2:0] == FU_STORE) begin
            if (lsu_ready_i) begin
              ack[0]       = 1'b1;
              commit_lsu_o = 1'b1;
              store_taken  = 1'b1;
            end
          end else if (fu_i[2:0] == FU_CSR) begin
            ack[0]       = 1'b1;
            we[0]        = 1'b1;
            csr_commit_o = 1'b1;
            sel_csr      = 1'b1;
          end else begin
            ack[0] = 1'b1;
            we[0]  = 1'b1;
          end
        end
        // Younger ports retire only as an unbroken prefix behind port 0.
        for (int k = 1; k < NR_PORTS; k++) begin
          port_ok = ack[k-1] && valid_i[k] && !ex_valid_i[k] &&
                    tail_fu_ok(fu_i[k*3 +: 3]) && (serial_i[k*2 +: 2] == 2'd0) &&
                    !amo_i[k] && !single_step_i && !halt_i;
          if (fu_i[k*3 +: 3] == FU_STORE) begin
            port_ok = port_ok && !store_taken && lsu_ready_i;
          end
          if (port_ok) begin
            ack[k] = 1'b1;
            if (fu_i[k*3 +: 3] == FU_STORE) begin
              commit_lsu_o      = 1'b1;
              commit_lsu_port_o = 3'(k);
              store_taken       = 1'b1;
            end else begin
              we[k] = 1'b1;
            end
          end
        end
      end

      ST_DRAIN: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (halt_i || !valid_i[0]) begin
          state_d = ST_IDLE;
        end else if (no_st_pending_i) begin
          ack[0]    = 1'b1;
          we[0]     = 1'b1;
          state_d   = ST_IDLE;
          fence_d   = (serial_i[1:0] == SER_FENCE);
          fence_i_d = (serial_i[1:0] == SER_FENCE_I);
          sfence_d  = (serial_i[1:0] == SER_SFENCE);
        end
      end

      ST_AMO: begin
        amo_valid_commit_o = 1'b1;
        if (amo_ack_i) begin
          ack[0]         = 1'b1;
          we[0]          = 1'b1;
          sel_amo        = 1'b1;
          flush_commit_o = 1'b1;
          state_d        = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    timeout_d = (state_d == ST_DRAIN) && (cnt_d == CNT_MAX);
  end

  // FPU flag accumulation and retired-instruction count for this cycle.
  always_comb begin
    fflags_o    = 5'd0;
    fflags_we_o = 1'b0;
    n_ret       = 4'd0;
    for (int k = 0; k < NR_PORTS; k++) begin
      n_ret = n_ret + {3'd0, ack[k]};
      if (ack[k] && (fu_i[k*3 +: 3] == FU_FPU)) begin
        fflags_o    = fflags_o | fflags_i[k*5 +: 5];
        fflags_we_o = 1'b1;
      end
    end
    instret_d = instret_q + 64'(n_ret);
  end

  // State, drain counter, flush pulses and instret register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      fence_q   <= 1'b0;
      fence_i_q <= 1'b0;
      sfence_q  <= 1'b0;
      instret_q <= 64'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      fence_q   <= fence_d;
      fence_i_q <= fence_i_d;
      sfence_q  <= sfence_d;
      instret_q <= instret_d;
    end
  end

  // Per-port write-back data; port 0 may take CSR or AMO data instead of the result.
  for (genvar gi = 0; gi < NR_PORTS; gi++) begin : g_port
    if (gi == 0) begin : g_head
      assign wdata_o[XLEN-1:0] = !valid_i[0] ? '0 :
                                 sel_amo    ? amo_result_i :
                                 sel_csr    ? csr_rdata_i : result_i[XLEN-1:0];
    end else begin : g_tail
      assign wdata_o[gi*XLEN +: XLEN] = valid_i[gi] ? result_i[gi*XLEN +: XLEN] : '0;
    end
    assign waddr_o[gi*5 +: 5] = valid_i[gi] ? rd_i[gi*5 +: 5] : 5'd0;
  end

  assign commit_ack_o    = ack;
  assign we_gpr_o        = we;
  assign fence_o         = fence_q;
  assign fence_i_o       = fence_i_q;
  assign sfence_vma_o    = sfence_q;
  assign instret_o       = instret_q;
  assign drain_timeout_o = timeout_q;

endmodule

// File: tb/tb_commit_stage_multi.sv
// tb_commit_stage_multi: vector table for single-cycle retirement plus
// hand-written FENCE / timeout / AMO / reset sequences, checked via a scoreboard.
module tb_commit_stage_multi;

  localparam logic [63:0] R0  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] CSR = 64'hC5C5_0000_1234_5678;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         halt_i, single_step_i;
  logic [3:0]   valid_i, ex_valid_i, amo_i;
  logic [11:0]  fu_i;
  logic [7:0]   serial_i;
  logic [19:0]  rd_i;
  logic [255:0] result_i;
  logic [19:0]  fflags_i;
  logic         lsu_ready_i, no_st_pending_i, amo_ack_i, csr_ex_i;
  logic [63:0]  amo_result_i, csr_rdata_i;
  logic [3:0]   commit_ack_o, we_gpr_o;
  logic [19:0]  waddr_o;
  logic [255:0] wdata_o;
  logic         commit_lsu_o;
  logic [2:0]   commit_lsu_port_o;
  logic         csr_commit_o, fflags_we_o;
  logic [4:0]   fflags_o;
  logic         fence_o, fence_i_o, sfence_vma_o, flush_commit_o;
  logic         amo_valid_commit_o, exception_valid_o, drain_timeout_o;
  logic [63:0]  instret_o;

  always #5 clk = ~clk;

  commit_stage_multi #(.NR_PORTS(4), .XLEN(64), .TIMEOUT_CYC(3)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .halt_i(halt_i), .single_step_i(single_step_i),
    .valid_i(valid_i), .ex_valid_i(ex_valid_i), .fu_i(fu_i), .serial_i(serial_i),
    .amo_i(amo_i), .rd_i(rd_i), .result_i(result_i), .fflags_i(fflags_i),
    .lsu_ready_i(lsu_ready_i), .no_st_pending_i(no_st_pending_i),
    .amo_ack_i(amo_ack_i), .amo_result_i(amo_result_i), .csr_rdata_i(csr_rdata_i),
    .csr_ex_i(csr_ex_i), .commit_ack_o(commit_ack_o), .we_gpr_o(we_gpr_o),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .commit_lsu_o(commit_lsu_o),
    .commit_lsu_port_o(commit_lsu_port_o), .csr_commit_o(csr_commit_o),
    .fflags_we_o(fflags_we_o), .fflags_o(fflags_o), .fence_o(fence_o),
    .fence_i_o(fence_i_o), .sfence_vma_o(sfence_vma_o),
    .flush_commit_o(flush_commit_o), .amo_valid_commit_o(amo_valid_commit_o),
    .exception_valid_o(exception_valid_o), .instret_o(instret_o),
    .drain_timeout_o(drain_timeout_o)
  );

  typedef struct {
    string       name;
    logic [3:0]  ack, we;
    logic        lsu;
    logic [2:0]  lsu_port;
    logic        excp, csr, ffwe;
    logic [4:0]  ff;
    logic        chk_wd;
    logic [63:0] wd0;
    logic        fence, fencei, sfence, flush, amovc, tmo;
  } exp_t;

  typedef struct {
    logic [3:0]  valid, ex;
    logic [11:0] fu;
    logic [7:0]  ser;
    logic [3:0]  amo;
    logic        halt, ss, lsu_rdy, csr_ex;
    exp_t        e;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          txn    = 0;
  logic [63:0] exp_instret = 64'd0;
  exp_t        sb[$];
  vec_t        vecs[19];

  function automatic exp_t mk_exp(string n, logic [3:0] ack, logic [3:0] we, logic lsu,
                                  logic [2:0] port, logic excp, logic csr, logic ffwe,
                                  logic [4:0] ff, logic chk_wd, logic [63:0] wd0);
    exp_t e;
    e.name = n; e.ack = ack; e.we = we; e.lsu = lsu; e.lsu_port = port;
    e.excp = excp; e.csr = csr; e.ffwe = ffwe; e.ff = ff; e.chk_wd = chk_wd; e.wd0 = wd0;
    e.fence = 1'b0; e.fencei = 1'b0; e.sfence = 1'b0;
    e.flush = 1'b0; e.amovc = 1'b0; e.tmo = 1'b0;
    return e;
  endfunction

  function automatic exp_t z(string n);
    return mk_exp(n, 4'd0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 64'd0);
  endfunction

  function automatic vec_t mk_vec(logic [3:0] valid, logic [3:0] ex, logic [11:0] fu,
                                  logic [7:0] ser, logic [3:0] amo, logic halt, logic ss,
                                  logic lsu_rdy, logic csr_ex, exp_t e);
    vec_t v;
    v.valid = valid; v.ex = ex; v.fu = fu; v.ser = ser; v.amo = amo;
    v.halt = halt; v.ss = ss; v.lsu_rdy = lsu_rdy; v.csr_ex = csr_ex; v.e = e;
    return v;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask

  // Push expectation, sample at the falling edge, pop and compare, then move past the next rising edge.
  task automatic cyc(input exp_t e);
    exp_t         g;
    logic [19:0]  wa;
    logic [191:0] wd_hi;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    for (int k = 0; k < 4; k++) begin
      wa[k*5 +: 5] = valid_i[k] ? rd_i[k*5 +: 5] : 5'd0;
      if (k > 0) wd_hi[(k-1)*64 +: 64] = valid_i[k] ? result_i[k*64 +: 64] : 64'd0;
    end
    chk({g.name, ".ack"},     64'(commit_ack_o),       64'(g.ack));
    chk({g.name, ".we"},      64'(we_gpr_o),           64'(g.we));
    chk({g.name, ".lsu"},     64'(commit_lsu_o),       64'(g.lsu));
    chk({g.name, ".lsuport"}, 64'(commit_lsu_port_o),  64'(g.lsu_port));
    chk({g.name, ".excp"},    64'(exception_valid_o),  64'(g.excp));
    chk({g.name, ".csr"},     64'(csr_commit_o),       64'(g.csr));
    chk({g.name, ".ffwe"},    64'(fflags_we_o),        64'(g.ffwe));
    chk({g.name, ".ff"},      64'(fflags_o),           64'(g.ff));
    chk({g.name, ".waddr"},   64'(waddr_o),            64'(wa));
    chk({g.name, ".wd_hi"},   64'(wdata_o[255:64] != wd_hi), 64'd0);
    if (g.chk_wd) chk({g.name, ".wd0"}, wdata_o[63:0], g.wd0);
    chk({g.name, ".fence"},   64'(fence_o),            64'(g.fence));
    chk({g.name, ".fencei"},  64'(fence_i_o),          64'(g.fencei));
    chk({g.name, ".sfence"},  64'(sfence_vma_o),       64'(g.sfence));
    chk({g.name, ".flush"},   64'(flush_commit_o),     64'(g.flush));
    chk({g.name, ".amovc"},   64'(amo_valid_commit_o), 64'(g.amovc));
    chk({g.name, ".tmo"},     64'(drain_timeout_o),    64'(g.tmo));
    chk({g.name, ".instret"}, instret_o,               exp_instret);
    exp_instret = exp_instret + 64'($countones(g.ack));
    $display("txn %0d %s ack=%b we=%b lsu=%b exc=%b instret=%0d", txn, g.name,
             commit_ack_o, we_gpr_o, commit_lsu_o, exception_valid_o, instret_o);
    txn++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 4'd0; ex_valid_i = 4'd0; amo_i = 4'd0; fu_i = {4{3'd1}}; serial_i = 8'd0;
    halt_i = 1'b0; single_step_i = 1'b0; lsu_ready_i = 1'b0; csr_ex_i = 1'b0;
    no_st_pending_i = 1'b0; amo_ack_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rd_i         = {5'd4, 5'd3, 5'd2, 5'd1};
    result_i     = {64'h4444, 64'h3333, 64'h2222, R0};
    fflags_i     = {5'd8, 5'd4, 5'd2, 5'd1};
    csr_rdata_i  = CSR;
    amo_result_i = 64'h0;
    idle_inputs();
    rst_ni = 1'b0;

    //                 valid  ex     fu {p3,p2,p1,p0}             ser    amo   hlt ss lsu cex
    vecs[0]  = mk_vec(4'h0, 4'h0, {3'd1,3'd1,3'd1,3'd1}, 8'h00, 4'h0, 0, 0, 1, 0,
                      mk_exp("idle",      4'b0000, 4'b0000, 0, 0, 0, 0, 0, 5'h00, 1, 64'd0));
    vecs[1]  = mk_vec(4'hF, 4'h0, {3'd1,3'd1,3'd1,3'd1}, 8'h00, 4'h0, 0, 0, 1, 0,
                      mk_exp("all_alu",   4'b1111, 4'b1111, 0, 0, 0, 0, 0, 5'h00, 1, R0));
    vecs[2]  = mk_vec(4'hF, 4'h0, {3'd1,3'd3,3'd1,3'd3}, 8'h00, 4'h0, 0, 0, 1, 0,
                      mk_exp("two_st",    4'b0011, 4'b0010, 1, 0, 0, 0, 0, 5'h00, 0, 64'd0));
    vecs[3]  = mk_vec(4'hF, 4'h0, {3'd1,3'd1,3'd3,3'd1}, 8'h00, 4'h0, 0, 0, 1, 0,
                      mk_exp("st_p1",     4'b1111, 4'b1101, 1, 1, 0, 0, 0, 5'h00, 0, 64'd0));
    vecs[4]  = mk_vec(4'hF, 4'h0, {3'd1,3'd1,3'd3,3'd1}, 8'h00, 4'h0, 0, 0, 0, 0,
                      mk_exp("st_nrdy",   4'b0001, 4'b0001, 0, 0, 0, 0, 0, 5'h00, 0, 64'd0));
    vecs[5]  = mk_vec(4'hF, 4'h2, {3'd1,3'd1,3'd1,3'd1}, 8'h00, 4'h0, 0, 0, 1, 0,
                      mk_exp("ex_p1",     4'b0001, 4'b0001, 0, 0, 0, 0, 0, 5'h00, 0, 64'd0));
    vecs[6]  = mk_vec(4'hF, 4'h0, {3'd1,3'd1,3'd1,3'd6}, 8'h00, 4'h0, 0, 0, 1, 1,
                      mk_exp("csr_ex",    4'b0000, 4'b0000, 0, 0, 1, 0, 0, 5'h00, 0, 64'd0));
    vecs[7]  = mk_vec(4'hF, 4'h0, {3'd1,3'd1,3'd1,3'd6}, 8'h00, 4'h0, 1, 0, 1, 1,
                      mk_exp("csr_halt",  4'b0000, 4'b0000, 0, 0, 0, 0, 0, 5'h00, 0, 64'd0));
    vecs[8]  = mk_vec(4'hF, 4'h0, {3'd1,3'd6,3'd1,3'd6}, 8'h00, 4'h0, 0, 0, 1, 0,
                      mk_exp("csr_ok",    4'b0011, 4'b0011, 0, 0, 0, 1, 0, 5'h00, 1, CSR));
    vecs[9]  = mk_vec(4'hF, 4'h0, {3'd7,3'd1,3'd7,3'd7}, 8'h00, 4'h0, 0, 0, 1, 0,
                      mk_exp("fpu",       4'b1111, 4'b1111, 0, 0, 0, 0, 1, 5'h0B, 1, R0));
    vecs[10] = mk_vec(4'hF, 4'h0, {3'd1,3'd1,3'd1,3'd1}, 8'h00, 4'h0, 0, 1, 1, 0,
                      mk_exp("sstep",     4'b0001, 4'b0001, 0, 0, 0, 0, 0, 5'h00, 0, 64'd0));
    vecs[11] = mk_vec(4'hF, 4'h0, {3'd1,3'd1,3'd1,3'd1}, 8'h04, 4'h0, 0, 0, 1, 0,
                      mk_exp("ser_p1",    4'b0001, 4'b0001, 0, 0, 0, 0, 0, 5'h00, 0, 64'd0));
    vecs[12] = mk_vec(4'hF, 4'h0, {3'd1,3'd1,3'd1,3'd1}, 8'h00, 4'h4, 0, 0, 1, 0,
                      mk_exp("amo_p2",    4'b0011, 4'b0011, 0, 0, 0, 0, 0, 5'h00, 0, 64'd0));
    vecs[13] = mk_vec(4'hF, 4'h0, {3'd1,3'd1,3'd0,3'd1}, 8'h00, 4'h0, 0, 0, 1, 0,
                      mk_exp("none_p1",   4'b0001, 4'b0001, 0, 0, 0, 0, 0, 5'h00, 0, 64'd0));
    vecs[14] = mk_vec(4'hF, 4'h1, {3'd1,3'd1,3'd1,3'd1}, 8'h00, 4'h0, 0, 0, 1, 0,
                      mk_exp("ex_p0",     4'b0000, 4'b0000, 0, 0, 1, 0, 0, 5'h00, 0, 64'd0));
    vecs[15] = mk_vec(4'hF, 4'h0, {3'd1,3'd1,3'd1,3'd1}, 8'h00, 4'h0, 1, 0, 1, 0,
                      mk_exp("halt",      4'b0000, 4'b0000, 0, 0, 0, 0, 0, 5'h00, 0, 64'd0));
    vecs[16] = mk_vec(4'hD, 4'h0, {3'd1,3'd1,3'd1,3'd1}, 8'h00, 4'h0, 0, 0, 1, 0,
                      mk_exp("hole",      4'b0001, 4'b0001, 0, 0, 0, 0, 0, 5'h00, 0, 64'd0));
    vecs[17] = mk_vec(4'hF, 4'h0, {3'd5,3'd4,3'd2,3'd7}, 8'h00, 4'h0, 0, 0, 1, 0,
                      mk_exp("mix_units", 4'b1111, 4'b1111, 0, 0, 0, 0, 1, 5'h01, 0, 64'd0));
    vecs[18] = mk_vec(4'hF, 4'h0, {3'd1,3'd1,3'd1,3'd3}, 8'h00, 4'h0, 0, 0, 0, 0,
                      mk_exp("st0_nrdy",  4'b0000, 4'b0000, 0, 0, 0, 0, 0, 5'h00, 0, 64'd0));

    // Reset state
    @(posedge clk); #1;
    cyc(z("reset0"));
    cyc(z("reset1"));
    rst_ni = 1'b1;
    cyc(z("post_reset"));

    // Single-cycle retirement table
    for (int i = 0; i < 19; i++) begin
      valid_i = vecs[i].valid; ex_valid_i = vecs[i].ex; fu_i = vecs[i].fu;
      serial_i = vecs[i].ser; amo_i = vecs[i].amo; halt_i = vecs[i].halt;
      single_step_i = vecs[i].ss; lsu_ready_i = vecs[i].lsu_rdy; csr_ex_i = vecs[i].csr_ex;
      cyc(vecs[i].e);
    end
    idle_inputs();
    cyc(z("gap0"));

    // FENCE: five drain cycles without ack, ack when stores drain, pulse one cycle later
    valid_i = 4'h1; serial_i = 8'h01;
    cyc(z("fence_enter"));
    for (int i = 1; i <= 5; i++) begin
      e = z("fence_wait"); e.tmo = (i >= 4); cyc(e);
    end
    no_st_pending_i = 1'b1;
    e = mk_exp("fence_ack", 4'b0001, 4'b0001, 0, 0, 0, 0, 0, 5'h00, 0, 64'd0);
    e.tmo = 1'b1; cyc(e);
    idle_inputs();
    e = z("fence_pulse"); e.fence = 1'b1; cyc(e);
    cyc(z("fence_done"));

    // SFENCE.VMA with stores already drained
    valid_i = 4'h1; serial_i = 8'h03; no_st_pending_i = 1'b1;
    cyc(z("sfence_enter"));
    cyc(mk_exp("sfence_ack", 4'b0001, 4'b0001, 0, 0, 0, 0, 0, 5'h00, 0, 64'd0));
    idle_inputs();
    e = z("sfence_pulse"); e.sfence = 1'b1; cyc(e);
    cyc(z("sfence_done"));

    // Drain timeout from the fourth drain cycle, cleared by a halt abort
    valid_i = 4'h1; serial_i = 8'h02;
    cyc(z("tmo_enter"));
    for (int i = 1; i <= 5; i++) begin
      e = z("tmo_wait"); e.tmo = (i >= 4); cyc(e);
    end
    halt_i = 1'b1;
    e = z("tmo_abort"); e.tmo = 1'b1; cyc(e);
    valid_i = 4'h0;
    cyc(z("tmo_cleared"));
    idle_inputs();

    // AMO: wait seven cycles (halt ignored), then ack with the AMO load value
    valid_i = 4'h1; amo_i = 4'h1; fu_i = {3'd1, 3'd1, 3'd1, 3'd2};
    cyc(z("amo_enter"));
    for (int i = 1; i <= 7; i++) begin
      halt_i = (i >= 4);
      e = z("amo_wait"); e.amovc = 1'b1; cyc(e);
    end
    amo_ack_i = 1'b1; amo_result_i = 64'hDEAD;
    e = mk_exp("amo_ack", 4'b0001, 4'b0001, 0, 0, 0, 0, 0, 5'h00, 1, 64'hDEAD);
    e.amovc = 1'b1; e.flush = 1'b1; cyc(e);
    idle_inputs();
    cyc(z("amo_done"));

    // Reset while draining returns to IDLE with no pulse and a cleared count
    valid_i = 4'h1; serial_i = 8'h01;
    cyc(z("rst_enter"));
    cyc(z("rst_drain"));
    rst_ni = 1'b0; exp_instret = 64'd0;
    cyc(z("rst_mid"));
    rst_ni = 1'b1; idle_inputs();
    cyc(z("rst_after"));
    valid_i = 4'h1;
    cyc(mk_exp("rst_idle", 4'b0001, 4'b0001, 0, 0, 0, 0, 0, 5'h00, 1, R0));
    idle_inputs();
    cyc(z("final"));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/commit_stage_multi.md
Name: commit_stage_multi

Overview:
- N-port in-order retirement block between the scoreboard head window and the register file, LSU commit buffer, CSR file and controller.
- Generalises single/dual-port commit to NR_PORTS ports and allows one store on any port per cycle.
- Serialising ops (FENCE, FENCE.I, SFENCE.VMA, AMO) go through a registered drain/wait FSM.
- Also keeps a retired-instruction counter and a store-drain timeout flag.

Parameters:
- NR_PORTS, 4, commit ports (1..8); port 0 is the oldest entry.
- XLEN, 64, data width.
- TIMEOUT_CYC, 1023, DRAIN cycles before drain_timeout_o asserts (>=1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset: asynchronous, active-low
- halt_i  in  1  halt request
- single_step_i  in  1  single-step mode; only port 0 may retire
- valid_i  in  NR_PORTS  entry valid
- ex_valid_i  in  NR_PORTS  entry carries an exception
- fu_i  in  NR_PORTS*3  unit: 0 NONE, 1 ALU, 2 LOAD, 3 STORE, 4 CTRL, 5 MULT, 6 CSR, 7 FPU
- serial_i  in  NR_PORTS*2  0 none, 1 FENCE, 2 FENCE_I, 3 SFENCE_VMA
- amo_i  in  NR_PORTS  entry is an AMO
- rd_i  in  NR_PORTS*5  destination register
- result_i  in  NR_PORTS*XLEN  result
- fflags_i  in  NR_PORTS*5  FPU flags
- lsu_ready_i  in  1  LSU commit buffer can accept
- no_st_pending_i  in  1  store buffer empty
- amo_ack_i  in  1  AMO finished
- amo_result_i  in  XLEN  AMO load value
- csr_rdata_i  in  XLEN  CSR read data
- csr_ex_i  in  1  CSR access faults
- commit_ack_o  out  NR_PORTS  retire entry
- we_gpr_o  out  NR_PORTS  regfile write enable
- waddr_o  out  NR_PORTS*5  equals rd_i
- wdata_o  out  NR_PORTS*XLEN  write data
- commit_lsu_o  out  1  commit one store
- commit_lsu_port_o  out  3  port of that store
- csr_commit_o  out  1  commit CSR op on port 0
- fflags_we_o  out  1  write fflags
- fflags_o  out  5  OR of fflags of retired FPU ops
- fence_o / fence_i_o / sfence_vma_o  out  1 each  registered one-cycle flush pulses
- flush_commit_o  out  1  pipeline flush after AMO
- amo_valid_commit_o  out  1  AMO may execute
- exception_valid_o  out  1  exception taken at port 0
- instret_o  out  64  retired instruction count
- drain_timeout_o  out  1  store drain too long

Behaviour:
- Reset: FSM=IDLE, instret_o=0, all pulses and drain_timeout_o=0. Combinational outputs are 0 while valid_i=0.
- Port 0 in IDLE, when valid & !ex & !halt:
  - Plain op: ack, we_gpr=1 (0 for STORE).
  - STORE: needs lsu_ready_i.
  - CSR: commits only if !csr_ex_i; wdata=csr_rdata_i.
  - FPU: fflags_we=1.
  - Serial op: not acked; go to DRAIN.
  - AMO: not acked; go to AMO_WAIT.
- Port k>0 acks iff all of:
  - ports 0..k-1 acked;
  - valid & !ex;
  - fu in {ALU, LOAD, STORE, CTRL, MULT, FPU}, serial=0, !amo;
  - !single_step_i, !halt_i, FSM=IDLE;
  - a STORE only if no lower port committed a store this cycle and lsu_ready_i.
- A blocked port blocks all higher ports.
- exception_valid_o = port-0 valid & (ex_valid | (fu==CSR & csr_ex_i)) & !halt_i & FSM==IDLE. No port acks that cycle.
- DRAIN:
  - Counter starts at 0.
  - When no_st_pending_i=1: ack port 0, assert the matching pulse on the next cycle, return to IDLE.
  - If the counter reaches TIMEOUT_CYC: drain_timeout_o=1 and held until leaving DRAIN.
  - Abort to IDLE with no ack if halt_i or !valid_i[0].
- AMO_WAIT:
  - amo_valid_commit_o=1.
  - On amo_ack_i: ack port 0, we_gpr[0]=1, wdata[0]=amo_result_i, flush_commit_o=1 that cycle, then IDLE.
  - halt_i is ignored in this state.
- instret_o += popcount(commit_ack_o) each cycle; wraps modulo 2^64.
- fflags_o is the OR over acked FPU ports; fflags_we_o is 1 if any acked port is FPU.
- Reset mid-DRAIN or mid-AMO_WAIT returns to IDLE immediately; no pulse is emitted.

Test Plan:
- 4 valid ALU entries, rd=1..4 -> commit_ack_o=4'b1111, we_gpr_o=4'b1111; instret_o 0->4 next cycle.
- Ports 0 and 2 are STORE, lsu_ready_i=1 -> ack=4'b0011, commit_lsu_port_o=0; next cycle, with port 2 shifted to head, it commits.
- Port 0 FENCE, no_st_pending_i low for 5 cycles -> DRAIN, no ack for 5 cycles; ack when it rises; fence_o pulses exactly 1 cycle, one cycle later.
- TIMEOUT_CYC=3, no_st_pending_i held 0 -> drain_timeout_o=1 from the 4th DRAIN cycle; clears on abort via halt_i.
- AMO at head, amo_ack_i after 7 cycles with result 0xDEAD -> amo_valid_commit_o high throughout; wdata_o[0]=0xDEAD, flush_commit_o=1 only on the ack cycle.
- Port 1 ex_valid=1, ports 0/2 ALU -> ack=4'b0001. Then port 0 CSR with csr_ex_i=1 -> ack=0, exception_valid_o=1. Then halt_i=1 -> exception_valid_o=0.
